// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default link parameters,
// common to the receiver and transmitter sides of the link.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 104;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; both flops
// reset to RST_VAL so an idle-high line does not look like a start bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Metastability chain: d -> meta_r -> q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx_link.sv
// UART receiver: 8N1-style frame decoder with mid-bit sampling, a one-entry
// valid/ready output register, frame-error and overrun pulses.
module uart_rx_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] CNT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_r;
  logic [TW-1:0]        timer_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  // Frame FSM plus output register; all outputs are driven from here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      // Consumer handshake; a byte completing this cycle overrides below
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          timer_r   <= '0;
          bit_cnt_r <= '0;
          if (!rx_s) begin
            state_r <= ST_START;
            busy_o  <= 1'b1;
          end
        end

        ST_START: begin
          if (timer_r == HALF_LAST) begin
            timer_r <= '0;
            if (rx_s) begin
              state_r <= ST_IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end

        ST_DATA: begin
          if (timer_r == BIT_LAST) begin
            timer_r   <= '0;
            shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + 1'b1;
            if (bit_cnt_r == CNT_LAST) begin
              state_r <= ST_STOP;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end

        ST_STOP: begin
          if (timer_r == BIT_LAST) begin
            timer_r   <= '0;
            bit_cnt_r <= '0;
            if (rx_s) begin
              state_r <= ST_IDLE;
              busy_o  <= 1'b0;
              // Output slot is free if empty or being emptied this very cycle
              if (!valid_o || ready_i) begin
                data_o  <= shift_r;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              state_r     <= ST_WAIT_IDLE;
              frame_err_o <= 1'b1;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          timer_r   <= '0;
          bit_cnt_r <= '0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_link.sv
// Self-checking bench for uart_rx_link at CLKS_PER_BIT=16, DATA_BITS=8.
module tb_uart_rx_link;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  always #5 clk = ~clk;

  uart_rx_link #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observation side: accepted bytes, pulse counts, protocol violations
  logic [7:0] acc_q[$];
  int         ferr_cnt = 0, ovr_cnt = 0, valid_cyc = 0;
  int         pulse_viol = 0, stab_viol = 0;
  logic       prev_ferr = 1'b0, prev_ovr = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_ferr = 1'b0;
      prev_ovr  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (frame_err_o) ferr_cnt++;
      if (overrun_o)   ovr_cnt++;
      if (valid_o)     valid_cyc++;
      if ((frame_err_o && prev_ferr) || (overrun_o && prev_ovr)) pulse_viol++;
      if (prev_hold && (!valid_o || data_o != prev_data)) stab_viol++;
      if (valid_o && ready_i) acc_q.push_back(data_o);
      prev_ferr = frame_err_o;
      prev_ovr  = overrun_o;
      prev_hold = valid_o && !ready_i;
      prev_data = data_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full frame; leaves rx_i at the stop-bit level on return
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_i = 1'b0;
    cyc(CPB);
    for (int i = 0; i < DB; i++) begin
      rx_i = d[i];
      cyc(CPB);
    end
    rx_i = stop;
    cyc(CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t       vecs[6];
  int         f0, o0, v0;
  int         got, exp_b;
  logic [7:0] exp_q[$];
  int         exp_ferr;
  logic [7:0] rd;
  logic       rst_bit;
  logic       seen_busy;
  int         done_at;
  int         bad;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h3C, 1'b0, 0, 1};

    rst     = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    cyc(3);
    check("rst_data",  data_o,      0);
    check("rst_valid", valid_o,     0);
    check("rst_ferr",  frame_err_o, 0);
    check("rst_ovr",   overrun_o,   0);
    check("rst_busy",  busy_o,      0);
    rst = 1'b0;
    cyc(20);

    // Table-driven single frames with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      acc_q.delete();
      f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cyc;
      send_frame(vecs[i].data, vecs[i].stop);
      rx_i = 1'b1;
      cyc(20);
      got   = (acc_q.size() > 0) ? int'(acc_q[0]) : -1;
      exp_b = vecs[i].stop ? int'(vecs[i].data) : -1;
      check($sformatf("vec%0d_nbytes", i), acc_q.size(), vecs[i].exp_bytes);
      check($sformatf("vec%0d_byte", i), got, exp_b);
      check($sformatf("vec%0d_valid_cycles", i), valid_cyc - v0, vecs[i].exp_bytes);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
      check($sformatf("vec%0d_busy", i), busy_o, 0);
    end

    // Short low glitch is rejected at the mid-start sample
    f0 = ferr_cnt; v0 = valid_cyc;
    seen_busy = 1'b0;
    done_at   = -1;
    rx_i = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      cyc(1);
      if (k == 4) rx_i = 1'b1;
      if (busy_o) seen_busy = 1'b1;
      else if (seen_busy && done_at < 0) done_at = k;
    end
    check("glitch_busy_cleared", (done_at >= 0) ? 1 : 0, 1);
    cyc(20);
    check("glitch_valid", valid_cyc - v0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Held-low break after a bad stop bit
    f0 = ferr_cnt; v0 = valid_cyc;
    send_frame(8'h3C, 1'b0);
    cyc(50);
    check("break_busy_held", busy_o, 1);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", valid_cyc - v0, 0);
    rx_i = 1'b1;
    cyc(10);
    check("break_busy_release", busy_o, 0);
    check("break_ferr_once", ferr_cnt - f0, 1);

    // Random frames against the frame-rule model
    acc_q.delete();
    exp_q.delete();
    exp_ferr = 0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int n = 0; n < 20; n++) begin
      rd      = 8'($urandom_range(0, 255));
      rst_bit = ($urandom_range(0, 3) != 0);
      send_frame(rd, rst_bit);
      rx_i = 1'b1;
      if (rst_bit) exp_q.push_back(rd);
      else exp_ferr++;
      cyc($urandom_range(2, 20));
    end
    cyc(20);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= acc_q.size() || acc_q[i] != exp_q[i]) bad++;
    end
    check("rand_nbytes", acc_q.size(), exp_q.size());
    check("rand_byte_mismatches", bad, 0);
    check("rand_ferr", ferr_cnt - f0, exp_ferr);
    check("rand_ovr", ovr_cnt - o0, 0);

    // Back-to-back frames with the consumer stalled
    ready_i = 1'b0;
    acc_q.delete();
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    cyc(5);
    check("ovr_valid_held", valid_o, 1);
    check("ovr_data_old", data_o, 8'h11);
    check("ovr_pulses", ovr_cnt - o0, 1);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    check("ovr_valid_drop", valid_o, 0);
    check("ovr_accepted_n", acc_q.size(), 1);
    check("ovr_accepted", (acc_q.size() > 0) ? int'(acc_q[0]) : -1, 8'h11);

    // Consumer accepts in the exact completion cycle of the next byte;
    // stop-bit sample falls on the 155th rising edge after the start bit
    acc_q.delete();
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        cyc(154);
        ready_i = 1'b1;
        cyc(1);
        ready_i = 1'b0;
      end
    join
    cyc(5);
    check("same_cyc_valid", valid_o, 1);
    check("same_cyc_data", data_o, 8'h22);
    check("same_cyc_ovr", ovr_cnt - o0, 0);
    check("same_cyc_acc_n", acc_q.size(), 1);
    check("same_cyc_acc", (acc_q.size() > 0) ? int'(acc_q[0]) : -1, 8'h11);

    // Reset during data bit 3 with a byte still pending
    rd   = 8'hC3;
    rx_i = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_i = rd[i];
      cyc(CPB);
    end
    rx_i = rd[3];
    cyc(6);
    rst = 1'b1;
    #1;
    check("midrst_data",  data_o,      0);
    check("midrst_valid", valid_o,     0);
    check("midrst_ferr",  frame_err_o, 0);
    check("midrst_ovr",   overrun_o,   0);
    check("midrst_busy",  busy_o,      0);
    rx_i = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(10);
    acc_q.delete();
    f0 = ferr_cnt;
    ready_i = 1'b1;
    send_frame(8'h5A, 1'b1);
    cyc(20);
    check("postrst_nbytes", acc_q.size(), 1);
    check("postrst_byte", (acc_q.size() > 0) ? int'(acc_q[0]) : -1, 8'h5A);
    check("postrst_ferr", ferr_cnt - f0, 0);

    check("pulse_width_violations", pulse_viol, 0);
    check("hold_stability_violations", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_link.md
UART_RX_LINK -- requirements
Module: uart_rx_link

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clk cycles per serial bit; legal values >= 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal values 5 to 8.
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port rx_i, input, 1, serial line, asynchronous to clk, idle high.
REQ-006 Port data_o, output, DATA_BITS, received byte, valid while valid_o is high.
REQ-007 Port valid_o, output, 1, received byte available.
REQ-008 Port ready_i, input, 1, consumer accepts byte when high with valid_o.
REQ-009 Port frame_err_o, output, 1, one-cycle pulse for a stop bit sampled low.
REQ-010 Port overrun_o, output, 1, one-cycle pulse when a completed byte is dropped.
REQ-011 Port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 rx_i SHALL pass through a 2-FF synchronizer reset to 1; the FSM uses only the synchronized value rx_s.
REQ-013 Frame format SHALL be 1 start bit (0), DATA_BITS data bits LSB first, no parity, 1 stop bit (1).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 In IDLE with rx_s=0: go to START, bit-timer cleared.
REQ-016 START SHALL sample rx_s when the bit-timer reaches CLKS_PER_BIT/2-1 (integer division); 0 -> DATA with timer cleared, 1 -> IDLE (glitch rejected, no output).
REQ-017 DATA SHALL sample rx_s every CLKS_PER_BIT cycles into a shift register, LSB first; after the DATA_BITS-th sample -> STOP.
REQ-018 STOP SHALL sample rx_s after CLKS_PER_BIT cycles; 1 -> byte completes, go to IDLE; 0 -> frame_err_o pulses in the next cycle, byte discarded, go to WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL stay until rx_s=1, then go to IDLE, so a held-low break produces exactly one frame_err_o pulse.
REQ-020 Bit-timer width SHALL be $clog2(CLKS_PER_BIT); the timer wraps to 0 on each bit sample.
REQ-021 On byte completion, valid_o and data_o SHALL update in the cycle after the stop-bit sample.
REQ-022 valid_o SHALL stay high and data_o stable until the cycle after valid_o and ready_i are both high.
REQ-023 Byte completing while valid_o=1 and ready_i=0: new byte dropped, data_o holds old byte, overrun_o pulses one cycle.
REQ-024 Byte completing in the same cycle as a valid_o and ready_i handshake: old byte accepted, new byte loaded, valid_o stays high, no overrun.
REQ-025 frame_err_o and overrun_o SHALL never stay high more than one consecutive cycle per event.

Reset
REQ-026 rst SHALL asynchronously force the FSM to IDLE, clear the timer, bit counter and shift register, and set the synchronizer flops to 1.
REQ-027 Reset values SHALL be data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; reception resumes at the next falling edge after reset release.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT/DATA_BITS constants, shared with the transmitter.
REQ-030 The synchronizer SHALL be a sub-module sync_2ff (1-bit, reset value parameter); all other logic stays in uart_rx_link.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-031 Frame 0xA5 with ready_i=1 -> valid_o high one cycle with data_o=0xA5; frame_err_o=0; overrun_o=0; busy_o low after the stop bit.
REQ-032 rx_i low for 4 cycles then high -> no valid_o, no frame_err_o; busy_o back to 0 within 8+3 cycles of the falling edge.
REQ-033 Frame 0x3C with stop bit 0, then line held low 50 cycles -> exactly one frame_err_o pulse, no valid_o; busy_o stays high until rx_i returns high.
REQ-034 Back-to-back 0x11 and 0x22 with ready_i=0 -> data_o=0x11 with valid_o held; one overrun_o pulse at 0x22 completion; then ready_i=1 -> valid_o drops the next cycle.
REQ-035 ready_i raised in the exact completion cycle of 0x22 while 0x11 is pending -> 0x11 accepted, data_o=0x22, valid_o stays high, overrun_o=0.
REQ-036 rst pulsed during data bit 3 of a frame -> all outputs 0 immediately; the next frame 0x5A is received correctly.
